// File: rtl/level_packetizer.sv
// level_packetizer: frames sync-gated ADC words into AXI4-Stream packets through a FIFO
module level_packetizer #(
  parameter int FIFO_DEPTH = 1024,
  parameter int MAX_LEN    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adc_data,
  input  logic        adc_data_valid,
  input  logic        sync,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        overflow,
  input  logic        overflow_clear,
  output logic [31:0] drop_count,
  output logic [31:0] packet_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(MAX_LEN) + 1;
  typedef enum logic {IDLE, CAPTURE} state_t;
  state_t            state_q, state_d;
  logic [31:0]       hold_q, hold_d;
  logic [LW-1:0]     len_q, len_d;
  logic [32:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q, rd_d;
  logic [CW-1:0]     cnt_q;
  logic              push, push_last, drop, do_push, pop, tvalid_d;
  logic              tvalid_q, tlast_q, overflow_q;
  logic [31:0]       tdata_q, drop_q, pkt_q;
  // Capture FSM: the hold register delays each word so the packet's last word is known when sync falls
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    len_d     = len_q;
    push      = 1'b0;
    push_last = 1'b0;
    if (state_q == IDLE) begin
      if (sync && adc_data_valid) begin
        hold_d  = adc_data;
        len_d   = LW'(1);
        state_d = CAPTURE;
      end
    end else if (!sync) begin
      push      = 1'b1;
      push_last = 1'b1;
      len_d     = '0;
      state_d   = IDLE;
    end else if (adc_data_valid) begin
      push      = 1'b1;
      push_last = len_q == LW'(MAX_LEN);
      hold_d    = adc_data;
      len_d     = push_last ? LW'(1) : len_q + LW'(1);
    end
  end
  // Non-last words leave one slot free so a started packet can always be closed
  assign drop     = push && (push_last ? cnt_q == CW'(FIFO_DEPTH) : cnt_q >= CW'(FIFO_DEPTH - 1));
  assign do_push  = push && !drop;
  assign pop      = tvalid_q && m_axis_tready;
  assign rd_d     = rd_q + AW'(pop);
  assign tvalid_d = (cnt_q - CW'(pop)) != '0;
  // FIFO storage, tlast kept in bit 32
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= {push_last, hold_q};
  // State, FIFO bookkeeping, registered output stage and status counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      len_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      len_q      <= len_d;
      wr_q       <= wr_q + AW'(do_push);
      rd_q       <= rd_d;
      cnt_q      <= cnt_q + CW'(do_push) - CW'(pop);
      tvalid_q   <= tvalid_d;
      tdata_q    <= tvalid_d ? mem_q[rd_d][31:0] : tdata_q;
      tlast_q    <= tvalid_d ? mem_q[rd_d][32] : 1'b0;
      overflow_q <= drop ? 1'b1 : overflow_clear ? 1'b0 : overflow_q;
      drop_q     <= (drop && drop_q != '1) ? drop_q + 32'd1 : drop_q;
      pkt_q      <= (do_push && push_last) ? pkt_q + 32'd1 : pkt_q;
    end
  end
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_q;
  assign packet_count  = pkt_q;
endmodule

// File: doc/level_packetizer.md
Name: level_packetizer

Overview:
- Consumer side of the ADC level-sync path.
- Takes the two-sample ADC word stream (adc_data/adc_data_valid) together with the packet sync level produced by the level-sync block.
- Frames the samples captured while sync is high into AXI4-Stream packets, with tlast on the final word.
- Buffers words in an internal FIFO toward the DMA/interconnect. Reports overflow and dropped words.

Parameters:
- FIFO_DEPTH, 1024: FIFO entries; power of 2, at least 4.
- MAX_LEN, 4096: maximum words per packet. Longer sync windows are split into MAX_LEN-word packets.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- adc_data  in  32  two ADC samples, [31:16] and [15:0].
- adc_data_valid  in  1  adc_data qualifier.
- sync  in  1  packet window level; 1 = capture.
- m_axis_tdata  out  32  output word.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tlast  out  1  last word of packet.
- overflow  out  1  sticky; set on any dropped word.
- overflow_clear  in  1  clears overflow (1-cycle pulse).
- drop_count  out  32  saturating count of dropped words.
- packet_count  out  32  wrapping count of words pushed with tlast=1.

Behaviour:
- Reset (synchronous, active-high) values:
  - State = IDLE.
  - Hold register empty; len = 0.
  - FIFO empty; m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tdata = 0.
  - overflow = 0; drop_count = 0; packet_count = 0.
  - Reset mid-packet discards the hold register and all FIFO contents. No tlast is emitted.
- One-word hold register (hold_data, hold_valid) delays each sample by one so the last word is known when sync falls.
- State machine, evaluated every clk:
  - IDLE, sync=1 and adc_data_valid=1:
    - hold <= adc_data; len <= 1; go to CAPTURE.
    - Samples with sync=0 are ignored.
  - CAPTURE, sync=1 and adc_data_valid=1:
    - If len < MAX_LEN: push {last=0, hold}; hold <= adc_data; len <= len+1.
    - If len == MAX_LEN: push {last=1, hold}; hold <= adc_data; len <= 1.
  - CAPTURE, sync=0:
    - Push {last=1, hold}; hold empty; len <= 0; go to IDLE.
    - adc_data_valid in that cycle is ignored.
  - CAPTURE, sync=1 and adc_data_valid=0: no action.
- Push to FIFO:
  - The drop decision uses the registered FIFO count at the start of the cycle. A simultaneous pop is not credited.
  - A non-last word is dropped when count >= FIFO_DEPTH-1. One slot is reserved for tlast words.
  - A last word is dropped only when count == FIFO_DEPTH.
  - This guarantees every packet with at least one word in the FIFO receives its tlast.
  - A packet whose non-last words were all dropped may emerge as a single tlast word. This is legal and is flagged by overflow.
  - On any drop: overflow <= 1; drop_count increments, saturating at 0xFFFFFFFF.
  - packet_count increments on every successful push with last=1.
- overflow_clear:
  - Clears overflow the next cycle.
  - If a drop occurs in the same cycle, the drop wins and overflow stays 1.
- FIFO output:
  - Show-ahead. A word pushed at edge N is visible with m_axis_tvalid=1 after edge N+1.
  - Pop occurs when tvalid && tready.
  - tdata and tlast stay stable while tvalid=1 and tready=0.
  - Simultaneous push and pop when not empty keeps count unchanged.
  - Full throughput: one word per clock with tready held at 1.
- Width rules:
  - len is clog2(MAX_LEN)+1 bits.
  - FIFO count is clog2(FIFO_DEPTH)+1 bits.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- Latency: sample to m_axis_tvalid is 2 cycles after the next qualifying event (next valid sample or sync fall).

Test Plan:
- Sync high for 5 valid words 0x00010001..0x00050005, then sync=0, tready=1 -> 5 AXIS beats in order; tlast only on 0x00050005; packet_count=1; overflow=0.
- MAX_LEN=4, sync high for 10 valid words -> packets of 4, 4, 2 words with tlast on words 4, 8 and 10; packet_count=3.
- Sync pulses high for 3 cycles with adc_data_valid=0 -> no output beats; packet_count=0. Separately, sync=0 with valid data -> nothing captured.
- FIFO_DEPTH=8, tready=0, sync high for 20 words then low -> FIFO holds 7 non-last words plus 1 last word (count 8); drop_count=12; overflow=1. Release tready -> 8 beats, tlast on the 8th. Pulse overflow_clear -> overflow=0, drop_count stays 12.
- tready toggling 1/0 every cycle over a 100-word packet -> all 100 words delivered; tdata and tlast stable during stalls; no drops.
- Assert reset during CAPTURE with 3 words in FIFO -> next cycle tvalid=0, all counters 0. The next sync window produces a clean packet.
